// File: rtl/cheri_alu_wbq.sv
// cheri_alu_wbq: in-order CHERI ALU write-back queue (issue side: issue_i/issue_rd_i/issue_id_i/issue_ready_o, capture side: alu_result_i, drain side: wb_valid_o/wb_ready_i/wb_rd_o/wb_id_o/wb_cap_o, plus flush_i and count_o)
package cheri_alu_wbq_pkg;
  typedef struct packed {
    logic        tag;
    logic [15:0] perms;
    logic [31:0] addr;
  } op_cap_t;
  localparam op_cap_t NULL_CAP = '0;
endpackage

module cheri_alu_wbq
  import cheri_alu_wbq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ID_W  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       issue_i,
  input  logic [4:0]                 issue_rd_i,
  input  logic [ID_W-1:0]            issue_id_i,
  output logic                       issue_ready_o,
  input  op_cap_t                    alu_result_i,
  input  logic                       flush_i,
  output logic                       wb_valid_o,
  input  logic                       wb_ready_i,
  output logic [4:0]                 wb_rd_o,
  output logic [ID_W-1:0]            wb_id_o,
  output op_cap_t                    wb_cap_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [4:0]      rd_q  [DEPTH];
  logic [ID_W-1:0] id_q  [DEPTH];
  op_cap_t         cap_q [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt;
  logic [CW:0]     occ;
  logic            pend, capture, pop;
  logic [4:0]      pend_rd;
  logic [ID_W-1:0] pend_id;
  assign capture       = pend && (pend_rd != 5'd0);
  assign pop           = wb_valid_o && wb_ready_i;
  assign occ           = {1'b0, cnt} + {{CW{1'b0}}, pend};
  assign issue_ready_o = occ < (CW+1)'(DEPTH);
  assign wb_valid_o    = cnt != '0;
  assign wb_rd_o       = rd_q[rd_ptr];
  assign wb_id_o       = id_q[rd_ptr];
  assign wb_cap_o      = cap_q[rd_ptr];
  assign count_o       = cnt;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      pend    <= 1'b0;
      pend_rd <= '0;
      pend_id <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]  <= '0;
        id_q[i]  <= '0;
        cap_q[i] <= NULL_CAP;
      end
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      pend   <= 1'b0;
    end else begin
      pend    <= issue_i && issue_ready_o;
      pend_rd <= issue_rd_i;
      pend_id <= issue_id_i;
      if (capture) begin
        rd_q[wr_ptr]  <= pend_rd;
        id_q[wr_ptr]  <= pend_id;
        cap_q[wr_ptr] <= alu_result_i;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(capture) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_cheri_alu_wbq.sv
// tb_cheri_alu_wbq: directed-vector bench with a queue-level reference model for cheri_alu_wbq
module tb_cheri_alu_wbq;
  import cheri_alu_wbq_pkg::*;
  localparam int DEPTH = 4;
  typedef struct {
    logic [4:0] rd;
    logic [3:0] id;
    op_cap_t    cap;
  } ent_t;
  logic       clk_i = 0, rst_i = 1;
  logic       issue_i = 0, issue_ready_o, flush_i = 0, wb_valid_o, wb_ready_i = 0;
  logic [4:0] issue_rd_i = 0, wb_rd_o;
  logic [3:0] issue_id_i = 0, wb_id_o;
  logic [2:0] count_o;
  op_cap_t    alu_result_i = '0, wb_cap_o;
  int         errs = 0, checks = 0, n_acc = 0, max_cnt = 0;
  logic [3:0] last_id = 0;
  ent_t       mq[$];
  bit         m_pend = 0;
  logic [4:0] m_rd = 0;
  logic [3:0] m_id = 0;
  logic [3:0] d_ids[$];
  logic [4:0] d_rds[$];
  cheri_alu_wbq #(.DEPTH(DEPTH), .ID_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .issue_i(issue_i), .issue_rd_i(issue_rd_i),
    .issue_id_i(issue_id_i), .issue_ready_o(issue_ready_o), .alu_result_i(alu_result_i),
    .flush_i(flush_i), .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rd_o(wb_rd_o),
    .wb_id_o(wb_id_o), .wb_cap_o(wb_cap_o), .count_o(count_o)
  );
  always #5 clk_i = ~clk_i;
  function automatic op_cap_t cap_of(input logic [3:0] id);
    op_cap_t c;
    c.tag   = 1'b1;
    c.perms = 16'hA5A0 | 16'(id);
    c.addr  = 32'h1000_0000 + 32'(id) * 16;
    return c;
  endfunction
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // reference model: a plain FIFO of results plus one in-flight op
  always @(posedge clk_i or posedge rst_i) begin
    int occ;
    if (rst_i || flush_i) begin
      mq.delete();
      m_pend = 0;
    end else begin
      occ = mq.size() + int'(m_pend);
      if (mq.size() != 0 && wb_ready_i) void'(mq.pop_front());
      if (m_pend && m_rd != 0) mq.push_back('{m_rd, m_id, alu_result_i});
      m_pend = issue_i && (occ < DEPTH);
      m_rd   = issue_rd_i;
      m_id   = issue_id_i;
    end
  end
  always @(posedge clk_i)
    if (!rst_i && !flush_i)
      assert (!(issue_i && !issue_ready_o)) else $error("issue while not ready");
  always @(negedge clk_i) begin
    if (!rst_i) begin
      check("valid", 64'(wb_valid_o), 64'(mq.size() != 0));
      check("count", 64'(count_o), 64'(mq.size()));
      check("ready", 64'(issue_ready_o), 64'((mq.size() + int'(m_pend)) < DEPTH));
      if (mq.size() != 0) begin
        check("head_rd", 64'(wb_rd_o), 64'(mq[0].rd));
        check("head_id", 64'(wb_id_o), 64'(mq[0].id));
        check("head_cap", 64'(wb_cap_o), 64'(mq[0].cap));
      end
      if (wb_valid_o && wb_ready_i && !flush_i) begin
        d_ids.push_back(wb_id_o);
        d_rds.push_back(wb_rd_o);
      end
      if (int'(count_o) > max_cnt) max_cnt = int'(count_o);
    end
  end
  task automatic cyc(input bit iss, input logic [4:0] rd, input logic [3:0] id,
                     input bit rdy, input bit fl, input bit gate);
    alu_result_i = cap_of(last_id);
    issue_i      = iss && (!gate || issue_ready_o);
    issue_rd_i   = rd;
    issue_id_i   = id;
    wb_ready_i   = rdy;
    flush_i      = fl;
    if (issue_i) last_id = id;
    if (issue_i && issue_ready_o && !fl) n_acc++;
    @(posedge clk_i);
    #2;
  endtask
  task automatic idle(input int n, input bit rdy);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, rdy, 0, 1);
  endtask
  task automatic clr();
    d_ids.delete();
    d_rds.delete();
    n_acc   = 0;
    max_cnt = 0;
  endtask
  initial begin
    repeat (2) @(posedge clk_i);
    #2;
    check("rst_count", 64'(count_o), 0);
    check("rst_valid", 64'(wb_valid_o), 0);
    check("rst_ready", 64'(issue_ready_o), 1);
    check("rst_rd", 64'(wb_rd_o), 0);
    check("rst_id", 64'(wb_id_o), 0);
    check("rst_cap", 64'(wb_cap_o), 0);
    rst_i = 0;
    idle(1, 1);
    // single op: visible two cycles after issue
    clr();
    cyc(1, 5, 3, 1, 0, 1);
    check("t1_notyet", 64'(wb_valid_o), 0);
    cyc(0, 0, 0, 1, 0, 1);
    check("t1_valid", 64'(wb_valid_o), 1);
    check("t1_rd", 64'(wb_rd_o), 5);
    check("t1_id", 64'(wb_id_o), 3);
    check("t1_cap", 64'(wb_cap_o), 64'h1_A5A3_1000_0030);
    idle(1, 1);
    check("t1_count0", 64'(count_o), 0);
    // fill with no drain, then drain in order
    clr();
    for (int i = 0; i < 6; i++) cyc(1, 5'(i + 1), 4'(i), 0, 0, 1);
    check("t2_accepted", 64'(n_acc), 4);
    check("t2_count", 64'(count_o), 4);
    check("t2_ready", 64'(issue_ready_o), 0);
    idle(1, 1);
    check("t2_ready_after_pop", 64'(issue_ready_o), 1);
    idle(5, 1);
    check("t2_drained", 64'(d_ids.size()), 4);
    for (int i = 0; i < 4 && i < d_ids.size(); i++) check("t2_order", 64'(d_ids[i]), 64'(i));
    // back-to-back streaming with wrap
    clr();
    for (int i = 0; i < 10; i++) cyc(1, 5'(i + 1), 4'(i), 1, 0, 1);
    idle(4, 1);
    check("t3_accepted", 64'(n_acc), 10);
    check("t3_outs", 64'(d_ids.size()), 10);
    for (int i = 0; i < 10 && i < d_ids.size(); i++) check("t3_order", 64'(d_ids[i]), 64'(i));
    check("t3_maxcnt_le1", 64'(max_cnt <= 1), 1);
    // rd==0 is dropped
    clr();
    cyc(1, 7, 1, 1, 0, 1);
    cyc(1, 0, 2, 1, 0, 1);
    cyc(1, 9, 3, 1, 0, 1);
    idle(4, 1);
    check("t4_outs", 64'(d_rds.size()), 2);
    if (d_rds.size() == 2) begin
      check("t4_rd0", 64'(d_rds[0]), 7);
      check("t4_rd1", 64'(d_rds[1]), 9);
      check("t4_id1", 64'(d_ids[1]), 3);
    end
    // flush with three entries and one in flight
    clr();
    for (int i = 0; i < 4; i++) cyc(1, 5'(i + 1), 4'(i + 8), 0, 0, 1);
    check("t5_count3", 64'(count_o), 3);
    check("t5_full", 64'(issue_ready_o), 0);
    cyc(1, 10, 12, 1, 1, 0);
    check("t5_count", 64'(count_o), 0);
    check("t5_valid", 64'(wb_valid_o), 0);
    check("t5_ready", 64'(issue_ready_o), 1);
    idle(4, 1);
    check("t5_no_wb", 64'(d_ids.size()), 0);
    // async reset mid-drain
    clr();
    for (int i = 0; i < 3; i++) cyc(1, 5'(i + 1), 4'(i + 4), 0, 0, 1);
    idle(2, 0);
    idle(1, 1);
    check("t6_count2", 64'(count_o), 2);
    rst_i = 1;
    #1;
    check("t6_count", 64'(count_o), 0);
    check("t6_valid", 64'(wb_valid_o), 0);
    check("t6_ready", 64'(issue_ready_o), 1);
    check("t6_rd", 64'(wb_rd_o), 0);
    check("t6_id", 64'(wb_id_o), 0);
    check("t6_cap", 64'(wb_cap_o), 0);
    @(posedge clk_i);
    #2;
    rst_i = 0;
    clr();
    cyc(1, 4, 6, 1, 0, 1);
    idle(3, 1);
    check("t6_after_outs", 64'(d_ids.size()), 1);
    if (d_ids.size() == 1) check("t6_after_id", 64'(d_ids[0]), 6);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/cheri_alu_wbq.md
# cheri_alu_wbq

Write-back result queue directly downstream of the CHERI ALU. Tracks the destination register and instruction id of each issued CHERI ALU op, captures the ALU's registered capability result one cycle after issue, and buffers it in a small FIFO. Results drain to the register-file write-back arbiter over a valid/ready handshake. Issue-side backpressure is credit-based so the queue can never overflow.

## Interface
- DEPTH, 4: number of queue entries (power of two, ≥2)
- ID_W, 4: width of the instruction id carried with each result
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- issue_i  in  1  CHERI ALU op issued this cycle (same strobe as the ALU's enable)
- issue_rd_i  in  5  destination register of the issued op
- issue_id_i  in  ID_W  instruction id of the issued op
- issue_ready_o  out  1  queue can accept an issue this cycle
- alu_result_i  in  op_cap_t  ALU result capability, valid the cycle after issue
- flush_i  in  1  discard all queued and in-flight results
- wb_valid_o  out  1  head entry valid
- wb_ready_i  in  1  write-back arbiter accepts head
- wb_rd_o  out  5  head destination register
- wb_id_o  out  ID_W  head instruction id
- wb_cap_o  out  op_cap_t  head result capability
- count_o  out  $clog2(DEPTH+1)  number of valid entries

## Operation
- State: DEPTH entries {rd, id, cap}; read/write pointers (log2 DEPTH bits, wrap modulo DEPTH); count; one in-flight stage {pend, pend_rd, pend_id}.
- Issue: when issue_i && issue_ready_o && !flush_i, load pend=1, pend_rd=issue_rd_i, pend_id=issue_id_i; otherwise pend=0.
- Capture: in a cycle with pend=1, write {pend_rd, pend_id, alu_result_i} at write pointer and advance it, unless pend_rd==0 (result dropped, no entry, no write-pointer move).
- issue_i while issue_ready_o=0 is a protocol violation: ignored by the block, flagged by bench assertion.
- Pop: wb_valid_o && wb_ready_i advances read pointer. Entry data is held stable while wb_valid_o=1 and not popped.
- count_next = count + capture − pop; simultaneous capture and pop leaves count unchanged.
- issue_ready_o = (count + pend) < DEPTH; depends on registered state only, not on wb_ready_i or issue_i (no combinational path in→out).
- wb_valid_o = (count != 0). wb_rd_o/wb_id_o/wb_cap_o are driven from the head entry; they are don't-care when wb_valid_o=0 but reset to zero / NULL cap.
- Flush: on the edge where flush_i=1, count, pointers and pend are cleared; issue, capture and pop in that cycle are discarded (wb_ready_i handshake in the flush cycle does not count as a pop for the arbiter's bookkeeping — arbiter must also drop it).
- No reordering: write-back order equals issue order, minus rd==0 ops.

## Timing
- Reset (rst_i high, async): count_o=0, wb_valid_o=0, issue_ready_o=1, pend=0, pointers=0, wb_rd_o=0, wb_id_o=0, wb_cap_o=NULL.
- Latency: issue in cycle N → ALU result on alu_result_i in N+1 → captured at end of N+1 → wb_valid_o=1 in N+2 (queue empty case). Minimum issue-to-write-back latency 2 cycles.
- Throughput: one issue and one pop per cycle sustained when wb_ready_i=1.
- Full: count+pend==DEPTH → issue_ready_o=0; a pop in cycle N raises issue_ready_o in N+1.
- Wrap-around: pointers wrap from DEPTH−1 to 0 without bubble.
- Reset asserted mid-operation: all state cleared immediately; in-flight result is lost.

## Test plan
- Single issue rd=5 id=3 at cycle 0, alu_result_i=capA at cycle 1, wb_ready_i=1 → wb_valid_o=1 at cycle 2 with wb_rd_o=5, wb_id_o=3, wb_cap_o=capA; count_o returns to 0 at cycle 3.
- DEPTH=4, wb_ready_i=0, issue every cycle → exactly 4 ops accepted, issue_ready_o=0 from the cycle after the 4th issue, count_o=4; raise wb_ready_i → entries drain in issue order, one per cycle.
- Back-to-back 10 issues with wb_ready_i=1 → pointers wrap, no bubbles, ids out 0..9 in order, count_o never exceeds 1.
- Issue rd=0 between rd=7 and rd=9 → only two write-backs (rd 7 then 9); count_o never counts the rd=0 op.
- Queue holding 3 entries plus pend=1, assert flush_i with issue_i=1 and wb_ready_i=1 → next cycle count_o=0, wb_valid_o=0, issue_ready_o=1, no later write-back of flushed ops.
- Assert rst_i asynchronously mid-drain with count_o=2 → outputs reach reset values without waiting for a clock edge.
